// File: rtl/bot_intr_pkg.sv
// Shared definitions for the Rojobot interrupt controller: FSM states,
// source indices, default port addresses and cause-register layout.
package bot_intr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } intr_state_e;

    localparam int NUM_SRC  = 3;
    localparam int SRC_UPD  = 0;
    localparam int SRC_BTN  = 1;
    localparam int SRC_TICK = 2;

    localparam logic [7:0] PORT_CAUSE_DEF = 8'h0E;
    localparam logic [7:0] PORT_MASK_DEF  = 8'h0F;

    // Cause read layout: {any_other_pending, ovr[2:0], 1'b0, cause[2:0]}
    localparam int CAUSE_ANY_BIT  = 7;
    localparam int CAUSE_OVR_LSB  = 4;
    localparam int CAUSE_SRC_LSB  = 0;
    localparam int EOI_CLR_LSB    = 4;

    // Fixed priority: lowest index wins, result is one-hot (or zero).
    function automatic logic [NUM_SRC-1:0] prio_pick(input logic [NUM_SRC-1:0] req);
        logic [NUM_SRC-1:0] gnt;
        gnt = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) gnt = NUM_SRC'(1) << i;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/bot_intr_ctrl_tick.sv
// Periodic tick source: free-running counter 0..TICK_DIV-1, one-cycle
// pulse while the counter sits at its terminal value.
module intr_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          wrap;

    assign wrap = (cnt_q == CW'(TICK_DIV - 1));
    assign tick = wrap;

    // Counter advances every clock and folds back to 0 after the terminal count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= wrap ? '0 : cnt_q + 1'b1;
    end

endmodule

// File: rtl/bot_intr_ctrl.sv
// Interrupt controller for the Rojobot PicoBlaze: merges bot update,
// button-rise and timer-tick events onto the single KCPSM6 interrupt
// line, with mask, cause/overrun reporting and firmware EOI.
module bot_intr_ctrl
    import bot_intr_pkg::*;
#(
    parameter int          TICK_DIV   = 100000,
    parameter logic [7:0]  PORT_CAUSE = PORT_CAUSE_DEF,
    parameter logic [7:0]  PORT_MASK  = PORT_MASK_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       upd_sysregs,
    input  logic [3:0] db_btns,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       read_strobe,
    input  logic       interrupt_ack,
    output logic       interrupt,
    output logic [7:0] rd_data,
    output logic       rd_sel
);

    intr_state_e        state_q;
    logic               interrupt_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] ovr_q, ovr_d;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] cause_q;
    logic [3:0]         btn_q;

    logic               tick;
    logic [NUM_SRC-1:0] ev;
    logic [NUM_SRC-1:0] pm;
    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] eoi_clr;
    logic               wr_mask, wr_eoi;
    logic               sel_cause, sel_mask;
    logic               unused_ok;

    intr_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign ev[SRC_UPD]  = upd_sysregs;
    assign ev[SRC_BTN]  = |(db_btns & ~btn_q);
    assign ev[SRC_TICK] = tick;

    assign pm        = pending_q & mask_q;
    assign sel_cause = (port_id == PORT_CAUSE);
    assign sel_mask  = (port_id == PORT_MASK);
    assign wr_mask   = write_strobe && sel_mask;
    assign wr_eoi    = write_strobe && sel_cause;
    assign eoi_clr   = wr_eoi ? out_port[EOI_CLR_LSB +: NUM_SRC] : '0;

    // Grant happens only on an ack taken in ASSERT with something still unmasked.
    assign grant = (state_q == ASSERT && interrupt_ack && |pm) ? prio_pick(pm) : '0;

    // Pending/overrun next state: a new event beats the grant clear on the
    // same source, and a clear-then-set is not an overrun.
    always_comb begin
        pending_d = (pending_q & ~grant) | ev;
        ovr_d     = (ovr_q & ~eoi_clr) | (ev & pending_q & ~grant);
    end

    // Source bookkeeping: button history, pending, overrun and mask.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q     <= '0;
            pending_q <= '0;
            ovr_q     <= '0;
            mask_q    <= 3'b001;
        end else begin
            btn_q     <= db_btns;
            pending_q <= pending_d;
            ovr_q     <= ovr_d;
            if (wr_mask) mask_q <= out_port[NUM_SRC-1:0];
        end
    end

    // Request/ack/EOI handshake with registered interrupt and cause.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            interrupt_q <= 1'b0;
            cause_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|pm) begin
                        state_q     <= ASSERT;
                        interrupt_q <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (!(|pm)) begin
                        state_q     <= IDLE;
                        interrupt_q <= 1'b0;
                    end else if (interrupt_ack) begin
                        state_q     <= SERVICE;
                        interrupt_q <= 1'b0;
                        cause_q     <= grant;
                    end
                end
                SERVICE: begin
                    if (wr_eoi) state_q <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    interrupt_q <= 1'b0;
                end
            endcase
        end
    end

    assign interrupt = interrupt_q;

    // Read mux; rd_sel is qualified by read_strobe so the bus mux only
    // claims in_port during an actual read of one of our ports.
    always_comb begin
        rd_data = '0;
        if (sel_cause) begin
            rd_data[CAUSE_ANY_BIT]                  = |pm;
            rd_data[CAUSE_OVR_LSB +: NUM_SRC]       = ovr_q;
            rd_data[CAUSE_SRC_LSB +: NUM_SRC]       = cause_q;
        end else if (sel_mask) begin
            rd_data[NUM_SRC-1:0] = mask_q;
        end
    end

    assign rd_sel = read_strobe && (sel_cause || sel_mask);

    assign unused_ok = ^{out_port[7], out_port[3]};

endmodule
